// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM select sequencer: state encodings, default
// channel count and the select-width helper.
package tdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    localparam int DEFAULT_N = 4;

    // At least one bit so N=1 still yields a legal vector.
    function automatic int sel_width(input int n);
        int w;
        for (w = 1; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/tdm_sel_cnt.sv
// Mod-N channel select counter: clr forces 0, en steps and wraps after N-1.
module tdm_sel_cnt #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/tdm_mux_seq.sv
// Time-division select sequencer: captures an N-bit word and serialises it one
// bit per clock with select/frame markers. Define TDM_PARITY_EN to append an
// even-parity bit after bit N-1 of every frame.
module tdm_mux_seq
    import tdm_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start
);

    state_t             state;
    logic [N-1:0]       word;
    logic               sel_last;
    logic               accept;
    logic               cnt_en;
    logic [SEL_W-1:0]   nxt_sel;

    // Ready only when the current frame ends this cycle, so a new word can follow with no gap.
    always_comb begin
        in_ready = 1'b1;
        case (state)
            ST_IDLE:  in_ready = 1'b1;
`ifdef TDM_PARITY_EN
            ST_SHIFT: in_ready = 1'b0;
`else
            ST_SHIFT: in_ready = sel_last;
`endif
            default:  in_ready = 1'b1;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign cnt_en  = (state == ST_SHIFT) && !sel_last;
    assign nxt_sel = sel + SEL_W'(1);

    tdm_sel_cnt #(
        .N (N),
        .W (SEL_W)
    ) u_sel_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (cnt_en),
        .cnt   (sel),
        .last  (sel_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            word        <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (accept) begin
                word        <= in_data;
                state       <= ST_SHIFT;
                ser_out     <= in_data[0];
                ser_valid   <= 1'b1;
                frame_start <= 1'b1;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (!sel_last) begin
                            ser_out <= word[nxt_sel];
                        end else begin
`ifdef TDM_PARITY_EN
                            state   <= ST_PAR;
                            ser_out <= ^word;
`else
                            state     <= ST_IDLE;
                            ser_valid <= 1'b0;
`endif
                        end
                    end
`ifdef TDM_PARITY_EN
                    ST_PAR: begin
                        state     <= ST_IDLE;
                        ser_valid <= 1'b0;
                    end
`endif
                    default: begin
                        ser_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux_seq.sv
// Self-checking bench for tdm_mux_seq: an N=4 and an N=3 instance, a frame-level
// queue model compared every cycle, plus hand-computed frame expectations.
module tb_tdm_mux_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din [2];
    logic       vin [2];
    logic       rdy [2];
    logic [1:0] selo [2];
    logic       so [2];
    logic       sv [2];
    logic       fs [2];

    int checks = 0;
    int passed = 0;
    bit cmp_en = 1'b0;
    int max_sel3 = 0;

    logic [7:0]  c_bits;
    logic [7:0]  c_vals;
    logic [7:0]  c_fs;
    logic [7:0]  c_rdy;
    logic [15:0] c_sels;

`ifdef TDM_PARITY_EN
    localparam logic [4:0] T2_VALS = 5'b11111;
    localparam logic [4:0] T2_RDY  = 5'b10000;
`else
    localparam logic [4:0] T2_VALS = 5'b01111;
    localparam logic [4:0] T2_RDY  = 5'b11000;
`endif

    tdm_mux_seq #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vin[0]),
        .in_ready(rdy[0]), .sel(selo[0]), .ser_out(so[0]),
        .ser_valid(sv[0]), .frame_start(fs[0])
    );

    tdm_mux_seq #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(din[1][2:0]), .in_valid(vin[1]),
        .in_ready(rdy[1]), .sel(selo[1]), .ser_out(so[1]),
        .ser_valid(sv[1]), .frame_start(fs[1])
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame-level model: each accepted word queues its beats; one beat is shown per clock.
    typedef struct {
        int sel;
        bit b;
        bit fs;
    } beat_t;

    beat_t q [2][$];
    beat_t cur;
    int    n_of [2] = '{4, 3};
    bit    m_valid [2];
    bit    m_ser [2];
    bit    m_fs [2];
    bit    m_rdy [2];
    int    m_sel [2];
    bit    par;

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                q[i].delete();
                m_valid[i] = 1'b0;
                m_ser[i]   = 1'b0;
                m_fs[i]    = 1'b0;
                m_sel[i]   = 0;
                m_rdy[i]   = 1'b1;
            end else begin
                if (vin[i] && m_rdy[i]) begin
                    par = 1'b0;
                    for (int k = 0; k < n_of[i]; k++) begin
                        q[i].push_back('{k, din[i][k], k == 0});
                        par ^= din[i][k];
                    end
`ifdef TDM_PARITY_EN
                    q[i].push_back('{n_of[i] - 1, par, 1'b0});
`endif
                end
                if (q[i].size() > 0) begin
                    cur        = q[i].pop_front();
                    m_valid[i] = 1'b1;
                    m_ser[i]   = cur.b;
                    m_fs[i]    = cur.fs;
                    m_sel[i]   = cur.sel;
                end else begin
                    m_valid[i] = 1'b0;
                    m_fs[i]    = 1'b0;
                end
                m_rdy[i] = (q[i].size() == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check_output($sformatf("in_ready%0d", i), rdy[i], m_rdy[i]);
                check_output($sformatf("sel%0d", i), selo[i], m_sel[i]);
                check_output($sformatf("ser_out%0d", i), so[i], m_ser[i]);
                check_output($sformatf("ser_valid%0d", i), sv[i], m_valid[i]);
                check_output($sformatf("frame_start%0d", i), fs[i], m_fs[i]);
            end
            if (int'(selo[1]) > max_sel3) max_sel3 = int'(selo[1]);
        end
    end

    task automatic wait_ready(input int idx);
        int n = 0;
        while (rdy[idx] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_output("ready_timeout", 0, 1);
    endtask

    task automatic apply_stimulus(input int idx, input logic [3:0] data);
        @(negedge clk);
        wait_ready(idx);
        #2;
        din[idx] = data;
        vin[idx] = 1'b1;
        @(posedge clk);
        #1;
        vin[idx] = 1'b0;
    endtask

    task automatic collect(input int idx, input int n, input int drop_at);
        c_bits = '0; c_vals = '0; c_fs = '0; c_rdy = '0; c_sels = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
            c_bits[k]       = so[idx];
            c_vals[k]       = sv[idx];
            c_fs[k]         = fs[idx];
            c_rdy[k]        = rdy[idx];
            c_sels[2*k +: 2] = selo[idx];
            if (k == drop_at) vin[idx] = 1'b0;
        end
    endtask

    initial begin
        din[0] = 4'h0; din[1] = 4'h0;
        vin[0] = 1'b1; vin[1] = 1'b1;

        // T1: reset held for three clocks with in_valid asserted
        @(negedge clk);
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_output("t1_ser_valid", sv[0], 0);
        check_output("t1_ser_out", so[0], 0);
        check_output("t1_frame_start", fs[0], 0);
        check_output("t1_sel", selo[0], 0);
        vin[0] = 1'b0; vin[1] = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 check_output("t1_in_ready", rdy[0], 1);

        // T2: single word 1011
        apply_stimulus(0, 4'b1011);
        collect(0, 5, -1);
        check_output("t2_bits", c_bits[3:0], 4'b1011);
        check_output("t2_sels", c_sels[7:0], 8'b11_10_01_00);
        check_output("t2_frame", c_fs[4:0], 5'b00001);
        check_output("t2_valid", c_vals[4:0], T2_VALS);
        check_output("t2_ready", c_rdy[4:0], T2_RDY);
        repeat (2) @(negedge clk);

`ifdef TDM_PARITY_EN
        // T4: parity frame for 0111
        apply_stimulus(0, 4'b0111);
        collect(0, 5, -1);
        check_output("t4_bits", c_bits[4:0], 5'b10111);
        check_output("t4_ready", c_rdy[4:0], 5'b10000);
        check_output("t4_valid", c_vals[4:0], 5'b11111);
`else
        // T3: back-to-back A then 5 with valid held
        @(negedge clk);
        wait_ready(0);
        #2;
        din[0] = 4'hA;
        vin[0] = 1'b1;
        @(posedge clk);
        #1 din[0] = 4'h5;
        collect(0, 8, 4);
        check_output("t3_bits", c_bits, 8'h5A);
        check_output("t3_valid", c_vals, 8'hFF);
        check_output("t3_frame", c_fs, 8'h11);
`endif
        repeat (3) @(negedge clk);

        // T5: reset pulse in the sel=2 cycle of 4'hF
        apply_stimulus(0, 4'hF);
        collect(0, 3, -1);
        check_output("t5_sel_before", c_sels[5:4], 2);
        #1 rst_n = 1'b0;
        #1;
        check_output("t5_valid_in_reset", sv[0], 0);
        check_output("t5_sel_in_reset", selo[0], 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        collect(0, 2, -1);
        check_output("t5_no_partial", c_vals[1:0], 2'b00);
        apply_stimulus(0, 4'h6);
        collect(0, 1, -1);
        check_output("t5_restart_sel", c_sels[1:0], 0);
        check_output("t5_restart_frame", c_fs[0], 1);
        check_output("t5_restart_bit", c_bits[0], 0);
        repeat (4) @(negedge clk);

        // T6: N=3 wrap behaviour
        apply_stimulus(1, 4'b0101);
        collect(1, 3, -1);
        check_output("t6_bits", c_bits[2:0], 3'b101);
        check_output("t6_sels", c_sels[5:0], 6'b10_01_00);
        apply_stimulus(1, 4'b0010);
        collect(1, 1, -1);
        check_output("t6_wrap_sel", c_sels[1:0], 0);
        check_output("t6_wrap_frame", c_fs[0], 1);
        check_output("t6_wrap_bit", c_bits[0], 0);
        repeat (5) @(negedge clk);
        check_output("t6_max_sel", max_sel3 <= 2, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
